// File: rtl/pkt_wr_master.sv
// pkt_wr_master: drains 32-bit words from the capture FIFO into memory as
// single-beat Avalon-MM writes covering pkt_len bytes starting at pkt_addr.
// Optional build macro PKT_HDR_EN: prepend one header beat holding the byte
// length, with the payload following at the next word address.
module pkt_wr_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     pkt_addr,
  input  logic [LEN_W-1:0]      pkt_len,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  fifo_rdreq,
  input  logic [DATA_W-1:0]     fifo_q,
  input  logic                  fifo_empty,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  output logic [LEN_W-1:0]      words_written
);

  localparam int unsigned NW_W = LEN_W + 1;
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
`ifdef PKT_HDR_EN
    , HDR = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_lo_q, len_lo_d;
  logic [NW_W-1:0]   nwords_q, nwords_d;
  logic              abort_pend_q, abort_pend_d;
  logic [LEN_W-1:0]  ww_d;
  logic              busy_d, done_d, aborted_d;
  logic [ADDR_W-1:0] avm_address_d;
  logic              avm_write_d;
  logic [DATA_W-1:0] avm_writedata_d;
  logic [BE_W-1:0]   avm_byteenable_d;
  logic              last_c;
  logic [BE_W-1:0]   be_last_c;

  // Word-alignment bits of the destination address are dropped by design.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^pkt_addr[1:0];

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      len_lo_q       <= '0;
      nwords_q       <= '0;
      abort_pend_q   <= 1'b0;
      words_written  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_lo_q       <= len_lo_d;
      nwords_q       <= nwords_d;
      abort_pend_q   <= abort_pend_d;
      words_written  <= ww_d;
      busy           <= busy_d;
      done           <= done_d;
      aborted        <= aborted_d;
      avm_address    <= avm_address_d;
      avm_write      <= avm_write_d;
      avm_writedata  <= avm_writedata_d;
      avm_byteenable <= avm_byteenable_d;
    end
  end

  // Next-state and next-output logic; fifo_rdreq is decoded combinationally
  // so that fifo_q is valid during LOAD.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_lo_d         = len_lo_q;
    nwords_d         = nwords_q;
    abort_pend_d     = abort_pend_q;
    ww_d             = words_written;
    aborted_d        = aborted;
    avm_address_d    = avm_address;
    avm_write_d      = avm_write;
    avm_writedata_d  = avm_writedata;
    avm_byteenable_d = avm_byteenable;
    fifo_rdreq       = 1'b0;

    last_c = (NW_W'(words_written) + NW_W'(1)) == nwords_q;

    unique case (len_lo_q)
      2'd1:    be_last_c = BE_W'(4'b0001);
      2'd2:    be_last_c = BE_W'(4'b0011);
      2'd3:    be_last_c = BE_W'(4'b0111);
      default: be_last_c = '1;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = {pkt_addr[ADDR_W-1:2], 2'b00};
          len_lo_d     = pkt_len[1:0];
          ww_d         = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
`ifdef PKT_HDR_EN
          nwords_d         = ((NW_W'(pkt_len) + NW_W'(3)) >> 2) + NW_W'(1);
          avm_address_d    = {pkt_addr[ADDR_W-1:2], 2'b00};
          avm_writedata_d  = DATA_W'(pkt_len);
          avm_byteenable_d = '1;
          avm_write_d      = 1'b1;
          state_d          = HDR;
`else
          nwords_d = (NW_W'(pkt_len) + NW_W'(3)) >> 2;
          state_d  = (pkt_len == '0) ? FIN : FETCH;
`endif
        end
      end
      FETCH: begin
        if (abort || abort_pend_q) begin
          aborted_d = 1'b1;
          state_d   = FIN;
        end else if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        avm_writedata_d  = fifo_q;
        avm_address_d    = addr_q + (ADDR_W'(words_written) << 2);
        avm_byteenable_d = last_c ? be_last_c : '1;
        avm_write_d      = 1'b1;
        state_d          = WRITE;
      end
`ifdef PKT_HDR_EN
      HDR,
`endif
      WRITE: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          ww_d        = words_written + LEN_W'(1);
          state_d     = last_c ? FIN : FETCH;
        end
      end
      FIN: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort arriving mid-beat is remembered and acted on at the next FETCH.
    if (abort && (state_q == LOAD || state_q == WRITE
`ifdef PKT_HDR_EN
        || state_q == HDR
`endif
        )) begin
      abort_pend_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

endmodule

// File: tb/tb_pkt_wr_master.sv
// Directed bench for pkt_wr_master with a FIFO model, a write monitor and an
// expected-beat scoreboard.
module tb_pkt_wr_master;

`ifdef PKT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] pkt_addr;
  logic [15:0] pkt_len;
  logic        busy, done, aborted, fifo_rdreq;
  logic [31:0] fifo_q = '0;
  logic        fifo_empty = 1'b1;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [15:0] words_written;

  logic        push_valid;
  logic [31:0] push_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_mem[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          rd_cnt = 0, rd_empty_cnt = 0;
  int          acc_cnt = 0, wr_hi = 0, hold_viol = 0;
  int          cyc = 0, last_acc_cyc = 0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat = '0;

  always #5 clk = ~clk;

  pkt_wr_master dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .busy(busy), .done(done), .aborted(aborted),
    .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .words_written(words_written)
  );

  // Normal-mode FIFO: data appears the cycle after rdreq, empty is registered.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      rd_cnt++;
      if (fifo_empty || fifo_mem.size() == 0) rd_empty_cnt++;
      else fifo_q <= fifo_mem.pop_front();
    end
    if (push_valid) fifo_mem.push_back(push_data);
    fifo_empty <= (fifo_mem.size() == 0);
  end

  // Write monitor: collects accepted beats and stall-stability violations.
  always @(posedge clk) begin
    if (avm_write) begin
      wr_hi++;
      if (prev_stall && ({avm_address, avm_writedata, avm_byteenable} != prev_beat))
        hold_viol++;
      prev_beat  = '{avm_address, avm_writedata, avm_byteenable};
      prev_stall = avm_waitrequest;
      if (!avm_waitrequest) begin
        got_q.push_back(prev_beat);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] l, input logic ab);
    @(negedge clk);
    pkt_addr = a;
    pkt_len  = l;
    start    = 1'b1;
    abort    = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Returns the number of negedges (counting the current one) until done.
  task automatic wait_done(input string tag, input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 72'(done), 72'(1));
  endtask

  task automatic wait_write(input string tag, input int budget);
    int n;
    n = 0;
    while (!avm_write && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_write_seen"}, 72'(avm_write), 72'(1));
  endtask

  task automatic drain(input string tag);
    beat_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) g = '0;
      else g = got_q.pop_front();
      check({tag, "_beat"}, 72'(g), 72'(e));
    end
    check({tag, "_extra_beats"}, 72'(got_q.size()), 72'(0));
    got_q.delete();
  endtask

  function automatic logic [3:0] last_be(input logic [1:0] l);
    case (l)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic push_hdr(input logic [31:0] a, input logic [15:0] l);
`ifdef PKT_HDR_EN
    exp_q.push_back('{align(a), 32'(l), 4'hF});
`endif
  endtask

  // Full packet with optional stall on the first beat; start may carry abort.
  task automatic run_pkt(input logic [31:0] addr, input logic [15:0] len,
                         input logic [31:0] d0, input int stall,
                         input logic with_abort, input string tag);
    int nw, nb, b_acc, b_hi, b_rd, b_hv, n;
    logic [31:0] base, d;
    nw   = (int'(len) + 3) / 4;
    nb   = nw + HDR;
    base = align(addr) + 32'(4 * HDR);
    push_hdr(addr, len);
    for (int i = 0; i < nw; i++) begin
      d = d0 + 32'(i) * 32'h1010_1010;
      push_word(d);
      exp_q.push_back('{base + 32'(4 * i), d, (i == nw - 1) ? last_be(len[1:0]) : 4'hF});
    end
    b_acc = acc_cnt; b_hi = wr_hi; b_rd = rd_cnt; b_hv = hold_viol;
    avm_waitrequest = (stall > 0);
    pulse_start(addr, len, with_abort);
    if (stall > 0) begin
      wait_write(tag, 50);
      repeat (stall) @(negedge clk);
      avm_waitrequest = 1'b0;
    end
    wait_done(tag, 200, n);
    check({tag, "_done_after_accept"}, 72'(cyc), 72'(last_acc_cyc + 1));
    drain(tag);
    check({tag, "_words_written"}, 72'(words_written), 72'(nb));
    check({tag, "_aborted"}, 72'(aborted), 72'(0));
    check({tag, "_accepts"}, 72'(acc_cnt - b_acc), 72'(nb));
    check({tag, "_rdreqs"}, 72'(rd_cnt - b_rd), 72'(nw));
    check({tag, "_write_hi_cycles"}, 72'(wr_hi - b_hi), 72'(nb + stall));
    check({tag, "_hold_stable"}, 72'(hold_viol - b_hv), 72'(0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 72'({done, busy}), 72'(0));
  endtask

  initial begin
    int n, b_acc, b_rd;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pkt_addr = '0; pkt_len = '0; avm_waitrequest = 1'b0;
    push_valid = 1'b0; push_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 72'({busy, done, aborted, fifo_rdreq, avm_write}), 72'(0));
    check("rst_bus", 72'({avm_address, avm_byteenable}), 72'(0));
    check("rst_words", 72'(words_written), 72'(0));
    reset = 1'b1;
    @(negedge clk);

    // Two full words, then unaligned address with short tail.
    run_pkt(32'h0000_1000, 16'd8, 32'hA1A2_A3A4, 0, 1'b0, "len8");
    run_pkt(32'h0000_2003, 16'd5, 32'h1234_5678, 0, 1'b1, "len5_startwins");
    run_pkt(32'h0000_3000, 16'd10, 32'h0BAD_F00D, 0, 1'b0, "len10");
    run_pkt(32'hFFFF_FFFC, 16'd3, 32'hCAFE_0001, 0, 1'b0, "len3_wrap");
    run_pkt(32'h0000_3100, 16'd4, 32'hDEAD_BEEF, 3, 1'b0, "stall3");

    // FIFO empty for 10 cycles before the word arrives.
    b_rd = rd_cnt;
    push_hdr(32'h5000, 16'd4);
    exp_q.push_back('{32'h5000 + 32'(4 * HDR), 32'h5555_AAAA, 4'hF});
    pulse_start(32'h5000, 16'd4, 1'b0);
    repeat (10) @(negedge clk);
    check("empty_no_rdreq", 72'(rd_cnt - b_rd), 72'(0));
    check("empty_busy", 72'(busy), 72'(1));
    push_word(32'h5555_AAAA);
    wait_done("empty", 100, n);
    drain("empty");
    check("empty_rd_when_empty", 72'(rd_empty_cnt), 72'(0));

    // Abort while stalled on an empty FIFO.
    b_acc = acc_cnt;
    push_hdr(32'h6000, 16'd8);
    pulse_start(32'h6000, 16'd8, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort_fetch", 20, n);
    check("abort_fetch_aborted", 72'(aborted), 72'(1));
    check("abort_fetch_accepts", 72'(acc_cnt - b_acc), 72'(HDR));
    check("abort_fetch_ww", 72'(words_written), 72'(HDR));
    drain("abort_fetch");

    // Abort during a stalled beat takes effect at the following FETCH.
    b_acc = acc_cnt;
    avm_waitrequest = 1'b1;
    push_hdr(32'h6800, 16'd8);
    for (int i = 0; i < 1 - HDR; i++) begin
      push_word(32'h7777_0000);
      exp_q.push_back('{32'h6800, 32'h7777_0000, 4'hF});
    end
    pulse_start(32'h6800, 16'd8, 1'b0);
    wait_write("abort_write", 50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'b0;
    wait_done("abort_write", 50, n);
    check("abort_write_aborted", 72'(aborted), 72'(1));
    check("abort_write_accepts", 72'(acc_cnt - b_acc), 72'(1));
    check("abort_write_ww", 72'(words_written), 72'(1));
    drain("abort_write");

    // Zero-length packet.
    b_acc = acc_cnt;
    push_hdr(32'h8000, 16'd0);
    pulse_start(32'h8000, 16'd0, 1'b0);
    wait_done("len0", 10, n);
    check("len0_latency_ok", 72'(n <= 2), 72'(1));
    check("len0_accepts", 72'(acc_cnt - b_acc), 72'(HDR));
    check("len0_aborted_cleared", 72'(aborted), 72'(0));
    drain("len0");

    // Reset in the middle of a stalled write, then a clean packet.
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 1 - HDR; i++) push_word(32'h9999_9999);
    pulse_start(32'h9000, 16'd4, 1'b0);
    wait_write("rst_mid", 50);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_async", 72'({avm_write, busy, done}), 72'(0));
    @(negedge clk);
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    got_q.delete();
    run_pkt(32'h0000_A000, 16'd12, 32'h0102_0304, 0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
